// File: rtl/ball_wall_probe_sched.sv
// Physics-tick scheduler: samples the ball cell each tick, probes neighbour walls over a
// shared req/gnt/rvalid read port and publishes all flags at once. Define BALL_PROBE_DIAG_EN for diagonal probes.
module ball_wall_probe_sched #(
  parameter int unsigned TICK_DIV = 1350000
) (
  input  logic        clk108MHz,
  input  logic        resetPressed,
  input  logic [7:0]  ballColumn,
  input  logic [7:0]  ballRow,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic        mem_rdata,
  output logic        wallAboveball,
  output logic        wallBelowball,
  output logic        wallLeftOfball,
  output logic        wallRightOfball,
  output logic        step_valid,
  output logic        busy,
  output logic        tick_overrun
`ifdef BALL_PROBE_DIAG_EN
  ,
  output logic [3:0]  wallDiag
`endif
);

`ifdef BALL_PROBE_DIAG_EN
  localparam int NP = 8;
`else
  localparam int NP = 4;
`endif
  localparam int IW = $clog2(NP);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NP - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NP-1:0] scratch_q, scratch_d;
  logic [NP-1:0] flags_q, flags_d;
  logic [7:0]    row_q, row_d, col_q, col_d;
  logic          overrun_q, overrun_d;
  logic          tick, advance;
  logic [2:0]    probeSel;
  logic [7:0]    probeRow, probeCol;
  logic          probeOut;

  always_comb begin
    tick    = (count_q == TICK_LAST);
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // Neighbour coordinates for the current probe; edge cells have no neighbour and read as wall.
  always_comb begin
    probeSel = 3'(idx_q);
    probeRow = row_q;
    probeCol = col_q;
    probeOut = 1'b1;
    case (probeSel)
      3'd0: begin probeRow = row_q - 8'd1; probeOut = (row_q == 8'd0);   end
      3'd1: begin probeRow = row_q + 8'd1; probeOut = (row_q == 8'd255); end
      3'd2: begin probeCol = col_q - 8'd1; probeOut = (col_q == 8'd0);   end
      3'd3: begin probeCol = col_q + 8'd1; probeOut = (col_q == 8'd255); end
`ifdef BALL_PROBE_DIAG_EN
      3'd4: begin
        probeRow = row_q - 8'd1; probeCol = col_q - 8'd1;
        probeOut = (row_q == 8'd0) || (col_q == 8'd0);
      end
      3'd5: begin
        probeRow = row_q - 8'd1; probeCol = col_q + 8'd1;
        probeOut = (row_q == 8'd0) || (col_q == 8'd255);
      end
      3'd6: begin
        probeRow = row_q + 8'd1; probeCol = col_q - 8'd1;
        probeOut = (row_q == 8'd255) || (col_q == 8'd0);
      end
      3'd7: begin
        probeRow = row_q + 8'd1; probeCol = col_q + 8'd1;
        probeOut = (row_q == 8'd255) || (col_q == 8'd255);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scratch_d = scratch_q;
    flags_d   = flags_q;
    row_d     = row_q;
    col_d     = col_q;
    mem_req   = 1'b0;
    advance   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          row_d     = ballRow;
          col_d     = ballColumn;
          idx_d     = '0;
          scratch_d = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (probeOut) begin
          scratch_d[idx_q] = 1'b1;
          advance          = 1'b1;
        end else begin
          mem_req = 1'b1;
          if (mem_gnt) state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          scratch_d[idx_q] = mem_rdata;
          advance          = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags load on the edge into DONE so they are already fresh while step_valid is high.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
        flags_d = scratch_d;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = REQ;
      end
    end
    overrun_d = overrun_q | (tick & (state_q != IDLE));
  end

  always_ff @(posedge clk108MHz or posedge resetPressed) begin
    if (resetPressed) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      scratch_q <= '0;
      flags_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      scratch_q <= scratch_d;
      flags_q   <= flags_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_addr        = mem_req ? {probeRow, probeCol} : 16'h0000;
  assign wallAboveball   = flags_q[0];
  assign wallBelowball   = flags_q[1];
  assign wallLeftOfball  = flags_q[2];
  assign wallRightOfball = flags_q[3];
  assign step_valid      = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign tick_overrun    = overrun_q;
`ifdef BALL_PROBE_DIAG_EN
  assign wallDiag        = flags_q[7:4];
`endif

endmodule

// File: tb/tb_ball_wall_probe_sched.sv
// Randomized bench for ball_wall_probe_sched: a behavioural maze memory with configurable
// grant stalls and read latency, checked against a probe-list model of the wall scheduler.
`timescale 1ns/1ps
module tb_ball_wall_probe_sched;

  localparam int TICK = 32;
`ifdef BALL_PROBE_DIAG_EN
  localparam int NPROBE = 8, MAXSTALL = 1, MAXDELAY = 1;
`else
  localparam int NPROBE = 4, MAXSTALL = 2, MAXDELAY = 2;
`endif

  logic        clk108MHz = 1'b0;
  logic        resetPressed = 1'b1;
  logic [7:0]  ballColumn = 8'd0, ballRow = 8'd0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_rdata = 1'b0;
  logic        wallAboveball, wallBelowball, wallLeftOfball, wallRightOfball;
  logic        step_valid, busy, tick_overrun;
`ifdef BALL_PROBE_DIAG_EN
  logic [3:0]  wallDiag;
`endif

  ball_wall_probe_sched #(.TICK_DIV(TICK)) dut (
    .clk108MHz(clk108MHz), .resetPressed(resetPressed),
    .ballColumn(ballColumn), .ballRow(ballRow),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wallAboveball(wallAboveball), .wallBelowball(wallBelowball),
    .wallLeftOfball(wallLeftOfball), .wallRightOfball(wallRightOfball),
    .step_valid(step_valid), .busy(busy), .tick_overrun(tick_overrun)
`ifdef BALL_PROBE_DIAG_EN
    , .wallDiag(wallDiag)
`endif
  );

  always #5 clk108MHz = ~clk108MHz;

  int cyc = 0;
  always @(posedge clk108MHz) cyc <= cyc + 1;

  // Maze memory: walls live in an associative set; per-request stall and latency tables.
  int          gntStall [8];
  int          rvDelay [8];
  bit          wallSet [int];
  bit          injectRv = 1'b0;
  int          grantCount = 0, seqBase = 0, logStart = 0;
  int          stallCnt = 0, rvCount = 0, stabErr = 0;
  bit          pendData = 1'b0, prevWaiting = 1'b0;
  logic [15:0] prevAddr = 16'h0;
  logic [15:0] grantLog [$];

  always @(negedge clk108MHz) begin
    int k;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (prevWaiting && (mem_req !== 1'b1 || mem_addr !== prevAddr)) stabErr++;
    if (rvCount > 0) begin
      rvCount--;
      if (rvCount == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pendData;
      end
    end else if (injectRv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 1'b1;
    end else if (mem_req === 1'b1) begin
      k = (grantCount - seqBase) % 8;
      if (stallCnt < gntStall[k]) begin
        stallCnt++;
      end else begin
        mem_gnt  = 1'b1;
        grantLog.push_back(mem_addr);
        pendData = wallSet.exists(int'(mem_addr)) ? 1'b1 : 1'b0;
        rvCount  = rvDelay[k];
        grantCount++;
        stallCnt = 0;
      end
    end else begin
      stallCnt = 0;
    end
    prevWaiting = (mem_req === 1'b1) && !mem_gnt;
    prevAddr    = mem_addr;
  end

  int           passCount = 0, checkCount = 0;
  logic [7:0]   expFlags, obsFlags;
  logic [135:0] expAddrs, obsAddrs;
  int           expLat, obsLat, obsHoldErr, riseCyc, relCyc;
  logic         obsBusyAfter;

  function automatic logic [7:0] getFlags();
`ifdef BALL_PROBE_DIAG_EN
    return {wallDiag, wallRightOfball, wallLeftOfball, wallBelowball, wallAboveball};
`else
    return {4'b0000, wallRightOfball, wallLeftOfball, wallBelowball, wallAboveball};
`endif
  endfunction

  function automatic logic [7:0] pickCoord();
    case ($urandom_range(0, 3))
      0:       return 8'd0;
      1:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic setZeroWait();
    for (int i = 0; i < 8; i++) begin
      gntStall[i] = 0;
      rvDelay[i]  = 1;
    end
  endtask

  // Reference: walk the probe list, edge neighbours flag as wall, in-range ones cost a full handshake.
  task automatic buildModel(input logic [7:0] r, input logic [7:0] c);
    int dr [8];
    int dc [8];
    int nr, nc, addr, k;
    dr = '{-1, 1, 0, 0, -1, -1, 1, 1};
    dc = '{0, 0, -1, 1, -1, 1, -1, 1};
    expFlags = 8'h00;
    expAddrs = '0;
    expLat   = 1;
    k        = 0;
    for (int p = 0; p < NPROBE; p++) begin
      nr = int'(r) + dr[p];
      nc = int'(c) + dc[p];
      if (nr < 0 || nr > 255 || nc < 0 || nc > 255) begin
        expFlags[p] = 1'b1;
        expLat += 1;
      end else begin
        addr = nr * 256 + nc;
        expFlags[p] = wallSet.exists(addr) ? 1'b1 : 1'b0;
        expLat += 1 + gntStall[k] + rvDelay[k];
        expAddrs[127:0] = {expAddrs[111:0], 16'(addr)};
        k++;
      end
    end
    expAddrs[135:128] = 8'(k);
  endtask

  task automatic waitRise(output int rise);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk108MHz); n++; end
    seqBase  = grantCount;
    logStart = grantLog.size();
    n = 0;
    while (busy !== 1'b1 && n < 3 * TICK) begin @(negedge clk108MHz); n++; end
    rise = (busy === 1'b1) ? cyc : -1;
  endtask

  task automatic observeSeq();
    int n = 0;
    logic [7:0] f0;
    obsLat = -1; obsFlags = 8'hxx; obsHoldErr = 0; obsBusyAfter = 1'bx; obsAddrs = '0;
    if (riseCyc < 0) return;
    f0 = getFlags();
    ballRow    = 8'($urandom);
    ballColumn = 8'($urandom);
    while (step_valid !== 1'b1 && n < 300) begin
      if (getFlags() !== f0) obsHoldErr++;
      @(negedge clk108MHz);
      n++;
    end
    if (step_valid === 1'b1) begin
      obsLat   = cyc - (riseCyc - 1);
      obsFlags = getFlags();
      @(negedge clk108MHz);
      obsBusyAfter = busy;
    end
    n = 0;
    for (int i = logStart; i < grantLog.size(); i++) begin
      obsAddrs[127:0] = {obsAddrs[111:0], grantLog[i]};
      n++;
    end
    obsAddrs[135:128] = 8'(n);
  endtask

  task automatic runSequence(input logic [7:0] r, input logic [7:0] c);
    ballRow    = r;
    ballColumn = c;
    waitRise(riseCyc);
    observeSeq();
  endtask

  task automatic doReset();
    @(negedge clk108MHz);
    resetPressed = 1'b1;
    repeat (3) @(negedge clk108MHz);
    resetPressed = 1'b0;
    relCyc = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk108MHz);
    checkCount++;
    if ({mem_req, mem_addr, getFlags(), step_valid, busy, tick_overrun} !== 28'h0)
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {mem_req, mem_addr, getFlags(), step_valid, busy, tick_overrun});
    else passCount++;
    setZeroWait();
    wallSet.delete();
    ballRow = 8'd3; ballColumn = 8'd4;
    resetPressed = 1'b0;
    relCyc = cyc;
    waitRise(riseCyc);
    checkCount++;
    if (riseCyc - relCyc !== TICK)
      $display("[TB] FAIL reset_first_tick: busy after %0d cycles, expected %0d", riseCyc - relCyc, TICK);
    else passCount++;
    checkCount++;
    if (mem_req !== 1'b1) $display("[TB] FAIL first_req: mem_req %b, expected 1", mem_req);
    else passCount++;
    checkCount++;
    if (mem_addr !== 16'h0204) $display("[TB] FAIL first_addr: got %h, expected 0204", mem_addr);
    else passCount++;
  endtask

  task automatic test_zero_wait();
    setZeroWait();
    wallSet.delete();
    wallSet[16'h0914] = 1'b1;
    wallSet[16'h0A15] = 1'b1;
    buildModel(8'd10, 8'd20);
    runSequence(8'd10, 8'd20);
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL zero_wait_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL zero_wait_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (obsAddrs !== expAddrs) $display("[TB] FAIL zero_wait_addrs: got %h, expected %h", obsAddrs, expAddrs);
    else passCount++;
    checkCount++;
    if (obsBusyAfter !== 1'b0) $display("[TB] FAIL zero_wait_busy_after: got %b, expected 0", obsBusyAfter);
    else passCount++;
    checkCount++;
    if (obsHoldErr !== 0) $display("[TB] FAIL zero_wait_flag_hold: %0d early changes, expected 0", obsHoldErr);
    else passCount++;
  endtask

  task automatic test_ignored_rvalid();
    int bad = 0;
    logic [7:0] f0;
    f0 = getFlags();
    injectRv = 1'b1;
    repeat (8) begin
      @(negedge clk108MHz);
      if (busy !== 1'b0 || step_valid !== 1'b0 || getFlags() !== f0) bad++;
    end
    injectRv = 1'b0;
    checkCount++;
    if (bad !== 0) $display("[TB] FAIL idle_rvalid_ignored: %0d disturbed cycles, expected 0", bad);
    else passCount++;
  endtask

  task automatic test_corner();
    setZeroWait();
    wallSet.delete();
    buildModel(8'd0, 8'd0);
    runSequence(8'd0, 8'd0);
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL corner_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL corner_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (obsAddrs !== expAddrs) $display("[TB] FAIL corner_addrs: got %h, expected %h", obsAddrs, expAddrs);
    else passCount++;
  endtask

  task automatic test_grant_stall();
    setZeroWait();
    gntStall[1] = 5;
    wallSet.delete();
    wallSet[16'h2020] = 1'b1;
    wallSet[16'h1F1F] = 1'b1;
    stabErr = 0;
    buildModel(8'd31, 8'd32);
    runSequence(8'd31, 8'd32);
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL stall_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL stall_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (obsAddrs !== expAddrs) $display("[TB] FAIL stall_addrs: got %h, expected %h", obsAddrs, expAddrs);
    else passCount++;
    checkCount++;
    if (obsHoldErr !== 0) $display("[TB] FAIL stall_flag_hold: %0d early changes, expected 0", obsHoldErr);
    else passCount++;
    checkCount++;
    if (stabErr !== 0) $display("[TB] FAIL stall_req_stable: %0d req/addr changes, expected 0", stabErr);
    else passCount++;
  endtask

  task automatic test_random();
    logic [7:0] r, c;
    int nr, nc;
    for (int it = 0; it < 6; it++) begin
      r = pickCoord();
      c = pickCoord();
      wallSet.delete();
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) begin
          nr = int'(r) + dr;
          nc = int'(c) + dc;
          if (nr >= 0 && nr <= 255 && nc >= 0 && nc <= 255 && $urandom_range(0, 1) == 1)
            wallSet[nr * 256 + nc] = 1'b1;
        end
      for (int i = 0; i < 8; i++) begin
        gntStall[i] = $urandom_range(0, MAXSTALL);
        rvDelay[i]  = $urandom_range(1, MAXDELAY);
      end
      buildModel(r, c);
      runSequence(r, c);
      checkCount++;
      if (obsLat !== expLat)
        $display("[TB] FAIL rand%0d_latency (%0d,%0d): got %0d, expected %0d", it, r, c, obsLat, expLat);
      else passCount++;
      checkCount++;
      if (obsFlags !== expFlags)
        $display("[TB] FAIL rand%0d_flags (%0d,%0d): got %b, expected %b", it, r, c, obsFlags, expFlags);
      else passCount++;
      checkCount++;
      if (obsAddrs !== expAddrs)
        $display("[TB] FAIL rand%0d_addrs (%0d,%0d): got %h, expected %h", it, r, c, obsAddrs, expAddrs);
      else passCount++;
    end
  endtask

  task automatic test_overrun();
    int steps = 0;
    checkCount++;
    if (tick_overrun !== 1'b0) $display("[TB] FAIL overrun_clear_before: got %b, expected 0", tick_overrun);
    else passCount++;
    setZeroWait();
    rvDelay[0] = 40;
    wallSet.delete();
    wallSet[16'h0914] = 1'b1;
    buildModel(8'd10, 8'd20);
    runSequence(8'd10, 8'd20);
    setZeroWait();
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL overrun_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL overrun_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (tick_overrun !== 1'b1) $display("[TB] FAIL overrun_set: got %b, expected 1", tick_overrun);
    else passCount++;
    repeat (10) begin
      @(negedge clk108MHz);
      if (step_valid === 1'b1) steps++;
    end
    checkCount++;
    if (steps !== 0) $display("[TB] FAIL overrun_extra_step: got %0d pulses, expected 0", steps);
    else passCount++;
    repeat (30) @(negedge clk108MHz);
    checkCount++;
    if (tick_overrun !== 1'b1) $display("[TB] FAIL overrun_sticky: got %b, expected 1", tick_overrun);
    else passCount++;
    doReset();
    checkCount++;
    if (tick_overrun !== 1'b0) $display("[TB] FAIL overrun_reset: got %b, expected 0", tick_overrun);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    setZeroWait();
    wallSet.delete();
    wallSet[16'h0914] = 1'b1;
    wallSet[16'h0A15] = 1'b1;
    buildModel(8'd10, 8'd20);
    runSequence(8'd10, 8'd20);
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL resetmid_pre_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    rvDelay[2] = 10;
    ballRow = 8'd10; ballColumn = 8'd20;
    waitRise(riseCyc);
    while (grantCount - seqBase < 3 && n < 100) begin @(negedge clk108MHz); n++; end
    @(negedge clk108MHz);
    resetPressed = 1'b1;
    #1;
    checkCount++;
    if ({mem_req, mem_addr, getFlags(), step_valid, busy, tick_overrun} !== 28'h0)
      $display("[TB] FAIL resetmid_outputs: got %h, expected 0",
               {mem_req, mem_addr, getFlags(), step_valid, busy, tick_overrun});
    else passCount++;
    repeat (2) @(negedge clk108MHz);
    resetPressed = 1'b0;
    relCyc = cyc;
    setZeroWait();
    wallSet.delete();
    wallSet[16'h0B14] = 1'b1;
    buildModel(8'd10, 8'd20);
    ballRow = 8'd10; ballColumn = 8'd20;
    waitRise(riseCyc);
    checkCount++;
    if (riseCyc - relCyc !== TICK)
      $display("[TB] FAIL resetmid_next_tick: busy after %0d cycles, expected %0d", riseCyc - relCyc, TICK);
    else passCount++;
    checkCount++;
    if (getFlags() !== 8'h00) $display("[TB] FAIL resetmid_late_rvalid: flags %b, expected 0", getFlags());
    else passCount++;
    observeSeq();
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL resetmid_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL resetmid_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (obsAddrs !== expAddrs) $display("[TB] FAIL resetmid_addrs: got %h, expected %h", obsAddrs, expAddrs);
    else passCount++;
  endtask

`ifdef BALL_PROBE_DIAG_EN
  task automatic test_diag();
    setZeroWait();
    wallSet.delete();
    wallSet[16'h0404] = 1'b1;
    buildModel(8'd5, 8'd5);
    runSequence(8'd5, 8'd5);
    checkCount++;
    if (obsLat !== expLat) $display("[TB] FAIL diag_latency: got %0d, expected %0d", obsLat, expLat);
    else passCount++;
    checkCount++;
    if (obsFlags !== expFlags) $display("[TB] FAIL diag_flags: got %b, expected %b", obsFlags, expFlags);
    else passCount++;
    checkCount++;
    if (obsAddrs !== expAddrs) $display("[TB] FAIL diag_addrs: got %h, expected %h", obsAddrs, expAddrs);
    else passCount++;
  endtask
`endif

  initial begin
    setZeroWait();
    $display("[TB] starting ball_wall_probe_sched bench, TICK_DIV=%0d probes=%0d", TICK, NPROBE);
    test_reset();
    test_zero_wait();
    test_ignored_rvalid();
    test_corner();
    test_grant_stall();
    test_random();
    test_overrun();
    test_reset_mid();
`ifdef BALL_PROBE_DIAG_EN
    test_diag();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ball_wall_probe_sched.md
# ball_wall_probe_sched

Physics-tick scheduler for the ball maze. It generates the motion tick and, on each tick, samples the current ball cell. It then runs a fixed sequence of neighbour-cell wall probes through a shared maze-map read port using a request/grant/valid handshake. When all probes finish, it publishes the four wall flags atomically and pulses `step_valid` so the ball motion datapath advances exactly one step on fresh collision data.

## Interface
- `TICK_DIV`, 1350000: physics tick period in clk108MHz cycles; legal range is ≥ 32.
- `clk108MHz` in 1: sole clock, rising edge.
- `resetPressed` in 1: asynchronous, active-high reset.
- `ballColumn` in 8: current ball column from the motion datapath.
- `ballRow` in 8: current ball row from the motion datapath.
- `mem_req` out 1: maze-map read request; held until granted.
- `mem_addr` out 16: probe address, `{row, column}` of the probed cell; stable while `mem_req` is high.
- `mem_gnt` in 1: grant; a transfer occurs on a cycle where both `mem_req` and `mem_gnt` are high.
- `mem_rvalid` in 1: read data valid, arriving one or more cycles after the grant.
- `mem_rdata` in 1: wall bit of the probed cell; 1 means wall.
- `wallAboveball` out 1: registered wall flag for the cell above the ball.
- `wallBelowball` out 1: registered wall flag for the cell below the ball.
- `wallLeftOfball` out 1: registered wall flag for the cell left of the ball.
- `wallRightOfball` out 1: registered wall flag for the cell right of the ball.
- `step_valid` out 1: one-cycle pulse; the wall flags are fresh on this cycle.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `tick_overrun` out 1: sticky error flag; a tick arrived while busy.

## Operation
- **Tick counter:** counts 0 to `TICK_DIV-1`, then wraps. The tick condition is `count == TICK_DIV-1`.
- **IDLE:** on tick, latch `ballRow`/`ballColumn`, clear probe index and scratch flags, go to REQ.
- **Probe order:** index 0 = above (row-1), 1 = below (row+1), 2 = left (col-1), 3 = right (col+1).
- **REQ, neighbour out of range:** row==0 for above, row==255 for below, col==0 for left, col==255 for right.
  - The scratch flag is set to 1 with no `mem_req` issued.
  - The FSM advances the index in one cycle: next probe is REQ, or DONE after index 3.
- **REQ, neighbour in range:** drive `mem_req`=1 and `mem_addr`. On `mem_gnt` go to WAIT; otherwise hold both unchanged.
- **WAIT:** `mem_req`=0. On `mem_rvalid`, store `mem_rdata` in the scratch slot and advance the index (REQ, or DONE after index 3).
- **Ignored `mem_rvalid`:** `mem_rvalid` in IDLE, REQ or DONE is ignored.
- **DONE:** copy all scratch flags to the wall outputs in one edge, assert `step_valid` for one cycle, return to IDLE.
- **Overrun:** a tick while not in IDLE is dropped and sets `tick_overrun`, which holds until reset. The in-flight sequence continues unaffected.
- **Input stability:** ball inputs that change mid-sequence have no effect; only the values latched in IDLE are used.
- **Reset values:** the counter, FSM (IDLE), `mem_req`, `mem_addr`, all wall flags, `step_valid`, `busy` and `tick_overrun` all reset to 0.
- **Reset mid-sequence:** all of the above return to reset values immediately (asynchronous). A `mem_rvalid` still pending in the memory after reset is ignored.

## Timing
- **Tick to first request:** tick on cycle t gives `busy`=1 and `mem_req`=1 at t+1.
- **Zero-wait memory** (grant in the request cycle, `mem_rvalid` the next cycle): each probe takes 2 cycles; DONE and `step_valid` at t+9; flags updated at t+9; `busy`=0 at t+10.
- **Skipped probe:** each one saves 1 cycle versus zero-wait memory.
- **Stall and latency:** each grant-stall or data-wait cycle adds 1 cycle. There is no timeout.
- **Output registers:** the wall flags change only on the `step_valid` cycle and are otherwise held.

## Configuration
- `BALL_PROBE_DIAG_EN` defined:
  - Adds output `wallDiag` [3:0], bit order {LR, LL, UR, UL}, reset 0.
  - Probes 4–7 (UL, UR, LL, LR) run after probe 3.
  - A diagonal probe is out of range if either of its coordinates is out of range; out-of-range diagonals are flagged 1.
  - Zero-wait latency becomes t+17.
- Undefined: `wallDiag` port absent; four probes only.

## Test plan
- **Zero-wait, mid-field:** `TICK_DIV`=32, ball (row 10, col 20), zero-wait memory returning walls at above and right.
  - Addresses 0x0914, 0x0B14, 0x0A13, 0x0A15 in that order.
  - `step_valid` at t+9; flags above=1, below=0, left=0, right=1.
- **Corner:** ball (0, 0); memory returns 0.
  - Only 2 requests (below 0x0100, right 0x0001); above=1, left=1; `step_valid` at t+7.
- **Grant stall:** `mem_gnt` low for 5 cycles on probe 1.
  - `mem_req` and `mem_addr` held stable throughout; `step_valid` at t+14.
  - Flags unchanged before `step_valid`.
- **Overrun:** `TICK_DIV`=32, `mem_rvalid` delayed 40 cycles.
  - Second tick dropped; `tick_overrun`=1 and held.
  - First sequence still completes with one `step_valid`.
- **Reset mid-sequence:** assert `resetPressed` during WAIT of probe 2.
  - All outputs 0 immediately; a late `mem_rvalid` is ignored.
  - Next tick arrives `TICK_DIV` cycles after reset release and runs a clean sequence.
- **With `BALL_PROBE_DIAG_EN`:** ball (5, 5), memory returns 1 only for 0x0404.
  - `wallDiag`=0001; `step_valid` at t+17.
